// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_seq
// Purpose  : Programmable LED pattern scheduler. A small step table holds a
//            {mode, duration} pair per step. The table is walked on a prescaled
//            tick, and the registered red/green LED levels are driven from the
//            flasher phase inputs.
// Options  : LEDSEQ_READBACK_EN adds a registered table/control readback port.
// Revision : 1.0  initial release
// ============================================================================
module led_pattern_seq #(
    parameter int STEP_AW  = 2,
    parameter int PRESCALE = 1000,
    parameter int PS_W     = 16
) (
    input  logic               xclk,
    input  logic               sys_rst,
    input  logic               wr_en,
    input  logic [STEP_AW:0]   wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               red_flash,
    input  logic               green_flash,
    output logic               led_r,
    output logic               led_g,
    output logic [STEP_AW-1:0] cur_step,
    output logic               busy,
    output logic               done,
`ifdef LEDSEQ_READBACK_EN
    input  logic [STEP_AW:0]   rd_addr,
    output logic [7:0]         rd_data,
`endif
    output logic               wrap
);

    localparam int                 N_STEPS    = 2 ** STEP_AW;
    localparam logic [PS_W-1:0]    c_PS_MAX   = PS_W'(PRESCALE - 1);
    localparam logic [STEP_AW-1:0] c_LAST_IDX = STEP_AW'(N_STEPS - 1);

    localparam logic [1:0] c_MODE_OFF  = 2'b00;
    localparam logic [1:0] c_MODE_ALT  = 2'b01;
    localparam logic [1:0] c_MODE_SYNC = 2'b10;
    localparam logic [1:0] c_MODE_ON   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [1:0]         r_mode [N_STEPS];
    logic [5:0]         r_dur  [N_STEPS];
    logic               r_enable;
    logic               r_loop;
    logic [STEP_AW-1:0] r_last;
    logic [PS_W-1:0]    r_ps;
    logic [5:0]         r_dcnt;
    logic [STEP_AW-1:0] r_cur_step;
    logic               r_led_r;
    logic               r_led_g;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic               w_step_wr;
    logic               w_ctl_wr;
    logic [STEP_AW-1:0] w_wr_idx;
    logic               w_en_now;
    logic               w_tick;
    logic               w_at_end;
    logic               w_stay_run;
    state_t             w_next_state;
    logic [STEP_AW-1:0] w_next_step;
    logic               w_reload;
    logic               w_dec;
    logic               w_wrap_set;
    logic [5:0]         w_load_dur;
    logic [1:0]         w_cur_mode;
    logic               w_led_r;
    logic               w_led_g;

    assign w_step_wr = wr_en & ~wr_addr[STEP_AW];
    assign w_ctl_wr  = wr_en &  wr_addr[STEP_AW];
    assign w_wr_idx  = wr_addr[STEP_AW-1:0];

    // A control write is acted on in the same cycle it arrives, so a disable
    // written in a tick cycle wins over the tick.
    assign w_en_now  = w_ctl_wr ? wr_data[0] : r_enable;

    assign w_tick    = (r_state == S_RUN) && (r_ps == c_PS_MAX);

    // The final step is either the programmed last index or, when last has
    // already been passed, the top of the table.
    assign w_at_end  = (r_cur_step == r_last) || (r_cur_step == c_LAST_IDX);

    // Duration loaded at step entry; a write to that same entry in the same
    // cycle is forwarded so the freshly written value is used.
    assign w_load_dur = (w_step_wr && (w_wr_idx == w_next_step)) ? wr_data[5:0]
                                                                 : r_dur[w_next_step];

    assign w_stay_run = (r_state == S_RUN) && (w_next_state == S_RUN);
    assign w_cur_mode = r_mode[r_cur_step];

    // Next-state and step-advance decisions
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_cur_step;
        w_reload     = 1'b0;
        w_dec        = 1'b0;
        w_wrap_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_step = '0;
                if (w_en_now) begin
                    w_next_state = S_RUN;
                    w_reload     = 1'b1;
                end
            end
            S_RUN: begin
                if (!w_en_now) begin
                    w_next_state = S_IDLE;
                    w_next_step  = '0;
                end else if (w_tick) begin
                    if (r_dcnt != 6'd0) begin
                        w_dec = 1'b1;
                    end else if (!w_at_end) begin
                        w_next_step = r_cur_step + STEP_AW'(1);
                        w_reload    = 1'b1;
                    end else if (r_loop) begin
                        w_next_step = '0;
                        w_reload    = 1'b1;
                        w_wrap_set  = 1'b1;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!w_en_now) begin
                    w_next_state = S_IDLE;
                    w_next_step  = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_step  = '0;
            end
        endcase
    end

    // LED level selected by the active step's mode
    always_comb begin
        w_led_r = 1'b0;
        w_led_g = 1'b0;
        case (w_cur_mode)
            c_MODE_OFF: begin
                w_led_r = 1'b0;
                w_led_g = 1'b0;
            end
            c_MODE_ALT: begin
                w_led_r = red_flash;
                w_led_g = green_flash;
            end
            c_MODE_SYNC: begin
                w_led_r = red_flash;
                w_led_g = red_flash;
            end
            c_MODE_ON: begin
                w_led_r = 1'b1;
                w_led_g = 1'b1;
            end
            default: begin
                w_led_r = 1'b0;
                w_led_g = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state register with registered busy/done status
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_RUN);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Step table: mode takes effect at once, duration only at next step entry
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            for (int i = 0; i < N_STEPS; i++) begin
                r_mode[i] <= '0;
                r_dur[i]  <= '0;
            end
        end else if (w_step_wr) begin
            r_mode[w_wr_idx] <= wr_data[7:6];
            r_dur[w_wr_idx]  <= wr_data[5:0];
        end
    end

    // Control register: enable, loop and last-step index
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            r_enable <= 1'b0;
            r_loop   <= 1'b0;
            r_last   <= '0;
        end else if (w_ctl_wr) begin
            r_enable <= wr_data[0];
            r_loop   <= wr_data[1];
            r_last   <= wr_data[2 +: STEP_AW];
        end
    end

    // Prescaler, duration counter, step index and wrap pulse
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            r_ps       <= '0;
            r_dcnt     <= '0;
            r_cur_step <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_cur_step <= w_next_step;
            r_wrap     <= w_wrap_set;
            if (w_reload) begin
                r_dcnt <= w_load_dur;
            end else if (w_dec) begin
                r_dcnt <= r_dcnt - 6'd1;
            end
            if (w_stay_run) begin
                r_ps <= w_tick ? '0 : (r_ps + PS_W'(1));
            end else begin
                r_ps <= '0;
            end
        end
    end

    // Registered LED drive, forced dark whenever the sequencer leaves RUN
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
        end else begin
            r_led_r <= w_stay_run & w_led_r;
            r_led_g <= w_stay_run & w_led_g;
        end
    end

`ifdef LEDSEQ_READBACK_EN
    logic [7:0] r_rd_data;
    logic [7:0] w_rd_ctl;

    // Control readback: status in the top two bits, config below
    always_comb begin
        w_rd_ctl      = 8'({r_last, r_loop, r_enable});
        w_rd_ctl[7:6] = {r_done, r_busy};
    end

    // Registered readback, one cycle of latency
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            r_rd_data <= '0;
        end else if (rd_addr[STEP_AW]) begin
            r_rd_data <= w_rd_ctl;
        end else begin
            r_rd_data <= {r_mode[rd_addr[STEP_AW-1:0]], r_dur[rd_addr[STEP_AW-1:0]]};
        end
    end

    assign rd_data = r_rd_data;
`endif

    assign led_r    = r_led_r;
    assign led_g    = r_led_g;
    assign cur_step = r_cur_step;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_seq
// Purpose  : Self-checking bench for led_pattern_seq (PRESCALE=4, 4 steps).
//            A behavioural model tracks the sequencer every cycle; directed
//            sequences and a mode table cover the named corner cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_seq;

    localparam int AW  = 2;
    localparam int NS  = 4;
    localparam int PSC = 4;

    logic          xclk;
    logic          sys_rst;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          red_flash;
    logic          green_flash;
    logic          led_r;
    logic          led_g;
    logic [AW-1:0] cur_step;
    logic          busy;
    logic          done;
    logic          wrap;
`ifdef LEDSEQ_READBACK_EN
    logic [AW:0]   rd_addr;
    logic [7:0]    rd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_seq #(
        .STEP_AW  (AW),
        .PRESCALE (PSC),
        .PS_W     (8)
    ) u_dut (
        .xclk        (xclk),
        .sys_rst     (sys_rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .red_flash   (red_flash),
        .green_flash (green_flash),
        .led_r       (led_r),
        .led_g       (led_g),
        .cur_step    (cur_step),
        .busy        (busy),
        .done        (done),
`ifdef LEDSEQ_READBACK_EN
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`endif
        .wrap        (wrap)
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    // ------------------------------------------------------------------
    // Behavioural model: phase name, remaining ticks of the current step,
    // and cycles elapsed within the current tick period.
    // ------------------------------------------------------------------
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic [1:0] m_mode [NS];
    logic [5:0] m_dur  [NS];
    bit         m_en, m_loop;
    int         m_last;
    int         m_phase, m_step, m_ticks_left, m_cyc;
    bit         m_led_r, m_led_g, m_wrap, m_busy, m_done;

    function automatic int dur_seen(input int idx);
        if (wr_en && !wr_addr[AW] && (int'(wr_addr[AW-1:0]) == idx))
            return int'(wr_data[5:0]);
        return int'(m_dur[idx]);
    endfunction

    task automatic model_update();
        bit ctlw, stepw, en_now, tick, was_run, wrp, lr, lg;
        int widx, nphase, nstep;
        logic [1:0] md;
        if (!sys_rst) begin
            for (int i = 0; i < NS; i++) begin
                m_mode[i] = 2'b00;
                m_dur[i]  = 6'd0;
            end
            m_en = 0; m_loop = 0; m_last = 0;
            m_phase = PH_IDLE; m_step = 0; m_ticks_left = 0; m_cyc = 0;
            m_led_r = 0; m_led_g = 0; m_wrap = 0; m_busy = 0; m_done = 0;
            return;
        end
        ctlw    = wr_en && wr_addr[AW];
        stepw   = wr_en && !wr_addr[AW];
        widx    = int'(wr_addr[AW-1:0]);
        en_now  = ctlw ? wr_data[0] : m_en;
        was_run = (m_phase == PH_RUN);
        tick    = was_run && (m_cyc == PSC - 1);
        md      = m_mode[m_step];
        lr      = (md == 2'b11) || ((md == 2'b01 || md == 2'b10) && red_flash);
        lg      = (md == 2'b11) || (md == 2'b01 && green_flash) || (md == 2'b10 && red_flash);
        wrp     = 0;
        nphase  = m_phase;
        nstep   = m_step;
        if (m_phase == PH_IDLE) begin
            nstep = 0;
            if (en_now) begin
                nphase = PH_RUN;
                m_cyc = 0;
                m_ticks_left = dur_seen(0) + 1;
            end
        end else if (m_phase == PH_RUN) begin
            if (!en_now) begin
                nphase = PH_IDLE;
                nstep = 0;
                m_cyc = 0;
            end else begin
                m_cyc = tick ? 0 : m_cyc + 1;
                if (tick) begin
                    m_ticks_left = m_ticks_left - 1;
                    if (m_ticks_left == 0) begin
                        if (m_step != m_last && m_step != NS - 1) begin
                            nstep = m_step + 1;
                            m_ticks_left = dur_seen(nstep) + 1;
                        end else if (m_loop) begin
                            nstep = 0;
                            m_ticks_left = dur_seen(0) + 1;
                            wrp = 1;
                        end else begin
                            nphase = PH_DONE;
                        end
                    end
                end
            end
        end else begin
            if (!en_now) begin
                nphase = PH_IDLE;
                nstep = 0;
            end
        end
        m_led_r = was_run && (nphase == PH_RUN) && lr;
        m_led_g = was_run && (nphase == PH_RUN) && lg;
        if (stepw) begin
            m_mode[widx] = wr_data[7:6];
            m_dur[widx]  = wr_data[5:0];
        end
        if (ctlw) begin
            m_en   = wr_data[0];
            m_loop = wr_data[1];
            m_last = int'(wr_data[3:2]);
        end
        m_phase = nphase;
        m_step  = nstep;
        m_wrap  = wrp;
        m_busy  = (nphase == PH_RUN);
        m_done  = (nphase == PH_DONE);
    endtask

    // Model stepped on every edge; DUT outputs compared shortly after
    always begin
        logic [6:0] exp_v, got_v;
        logic [1:0] st;
        @(posedge xclk);
        model_update();
        #2;
        st    = m_step[1:0];
        exp_v = {m_led_r, m_led_g, st, m_busy, m_done, m_wrap};
        got_v = {led_r, led_g, cur_step, busy, done, wrap};
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL model t=%0t {r,g,step,busy,done,wrap}: got %b expected %b",
                     $time, got_v, exp_v);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge xclk);
        #1;
    endtask

    task automatic wr(input logic [AW:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       rf;
        logic       gf;
        logic       exp_r;
        logic       exp_g;
    } vec_t;

    vec_t vt [8];

    localparam logic [AW:0] A_CTL = 3'd4;

    initial begin
        int wraps, pos1, pos2, busy_low;

        vt[0] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[4] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[5] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0};

        sys_rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        red_flash = 1'b0; green_flash = 1'b0;
`ifdef LEDSEQ_READBACK_EN
        rd_addr = '0;
`endif

        // Reset with write strobes active: nothing may be captured
        wr_en = 1'b1; wr_addr = A_CTL; wr_data = 8'h0F;
        cyc();
        chk("rst_outputs_a", int'({led_r, led_g, cur_step, busy, done, wrap}), 0);
        wr_addr = 3'd0; wr_data = 8'hFF;
        cyc();
        chk("rst_outputs_b", int'({led_r, led_g, cur_step, busy, done, wrap}), 0);
        wr_en = 1'b0; sys_rst = 1'b1;
        cyc();
        chk("rst_ctl_enable_clear", int'(busy), 0);
        wr(A_CTL, 8'h01);
        chk("rst_run_start", int'(busy), 1);
        repeat (3) cyc();
        chk("rst_step0_dur0_notdone", int'(done), 0);
        cyc();
        chk("rst_step0_dur0_done", int'(done), 1);
        chk("rst_step0_off_led", int'({led_r, led_g}), 0);
        wr(A_CTL, 8'h00);

        // Four-step one-shot sequence
        wr(3'd0, 8'h41); wr(3'd1, 8'h80); wr(3'd2, 8'hC2); wr(3'd3, 8'h00);
        red_flash = 1'b1; green_flash = 1'b0;
        wr(A_CTL, 8'h0D);
        chk("seq_busy_e0", int'(busy), 1);
        chk("seq_step_e0", int'(cur_step), 0);
        repeat (8) cyc();
        chk("seq_step_e8", int'(cur_step), 1);
        chk("seq_alt_led_e8", int'({led_r, led_g}), 2);
        red_flash = 1'b0;
        repeat (4) cyc();
        chk("seq_step_e12", int'(cur_step), 2);
        chk("seq_sync_led_e12", int'({led_r, led_g}), 0);
        cyc();
        chk("seq_on_led_e13", int'({led_r, led_g}), 3);
        repeat (11) cyc();
        chk("seq_step_e24", int'(cur_step), 3);
        repeat (3) cyc();
        chk("seq_notdone_e27", int'({busy, done}), 2);
        cyc();
        chk("seq_done_e28", int'({busy, done}), 1);
        chk("seq_done_led", int'({led_r, led_g}), 0);

        // DONE does not restart on enable alone
        wr(A_CTL, 8'h0D);
        cyc();
        chk("done_rewrite_stays", int'({busy, done}), 1);
        wr(A_CTL, 8'h00);
        chk("done_clear_idle", int'({busy, done, cur_step}), 0);
        wr(A_CTL, 8'h0D);
        chk("done_restart_busy", int'(busy), 1);
        chk("done_restart_step", int'(cur_step), 0);

        // Disable written in the tick cycle of step 1
        repeat (8) cyc();
        chk("dis_step1", int'(cur_step), 1);
        repeat (3) cyc();
        wr(A_CTL, 8'h00);
        chk("dis_idle_busy", int'(busy), 0);
        chk("dis_idle_step", int'(cur_step), 0);
        chk("dis_idle_led", int'({led_r, led_g}), 0);

        // Looping: one wrap per 28 cycles
        wr(A_CTL, 8'h0F);
        wraps = 0; pos1 = -1; pos2 = -1; busy_low = 0;
        for (int n = 1; n <= 60; n++) begin
            cyc();
            if (busy !== 1'b1) busy_low++;
            if (wrap === 1'b1) begin
                wraps++;
                if (pos1 < 0) pos1 = n;
                else if (pos2 < 0) pos2 = n;
                if (cur_step !== 2'd0) busy_low += 100;
            end
        end
        chk("loop_wrap_count", wraps, 2);
        chk("loop_wrap_pos1", pos1, 28);
        chk("loop_wrap_pos2", pos2, 56);
        chk("loop_busy_steady", busy_low, 0);
        wr(A_CTL, 8'h00);

        // Mode table on a long-running step 0
        wr(3'd0, 8'h3F);
        wr(A_CTL, 8'h01);
        cyc();
        for (int i = 0; i < 8; i++) begin
            wr(3'd0, {vt[i].mode, 6'h3F});
            red_flash = vt[i].rf; green_flash = vt[i].gf;
            cyc();
            chk($sformatf("mode_vec%0d_r", i), int'(led_r), int'(vt[i].exp_r));
            chk($sformatf("mode_vec%0d_g", i), int'(led_g), int'(vt[i].exp_g));
        end
        wr(A_CTL, 8'h00);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 299));
            wr_en = 1'b0; sys_rst = 1'b1;
            if (r < 20) begin
                wr_en = 1'b1;
                wr_addr = {1'b0, 2'($urandom_range(0, 3))};
                wr_data = {2'($urandom_range(0, 3)), 4'd0, 2'($urandom_range(0, 3))};
            end else if (r < 26) begin
                wr_en = 1'b1;
                wr_addr = A_CTL;
                wr_data = {4'd0, 3'($urandom_range(0, 7)), 1'b1};
            end else if (r < 29) begin
                wr_en = 1'b1;
                wr_addr = A_CTL;
                wr_data = 8'h00;
            end else if (r == 29) begin
                sys_rst = 1'b0;
            end
            red_flash   = 1'($urandom_range(0, 1));
            green_flash = 1'($urandom_range(0, 1));
            cyc();
        end
        wr_en = 1'b0; sys_rst = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Programmable LED pattern scheduler that replaces the static MiscReg pattern mux.
- Holds a small step table. Each step has a mode and a duration, both written over the pifctl register write strobe.
- Walks the table on a prescaled tick and drives the registered red/green LED levels from the red_flash/green_flash sources.
- Sits between pifctl/pif_flasher and the OB output buffers.

Parameters:
- STEP_AW, 2: step-index width; N_STEPS = 2**STEP_AW, legal STEP_AW range 1..6.
- PRESCALE, 1000: xclk cycles per tick, >= 2.
- PS_W, 16: prescaler counter width, must hold PRESCALE-1.

Ports:
- xclk  in  1  system clock.
- sys_rst  in  1  synchronous active-low reset.
- wr_en  in  1  single-cycle write strobe (from XI_PWr decode).
- wr_addr  in  STEP_AW+1  addr[STEP_AW]=0: step entry addr[STEP_AW-1:0]; =1: control register.
- wr_data  in  8  write data.
- red_flash  in  1  flasher red phase.
- green_flash  in  1  flasher green phase.
- led_r  out  1  registered red LED drive.
- led_g  out  1  registered green LED drive.
- cur_step  out  STEP_AW  index of the active step.
- busy  out  1  sequencer in RUN.
- done  out  1  sequencer in DONE.
- wrap  out  1  one-cycle pulse on loop wrap-around.

Behaviour:
- One clock: xclk. Reset is synchronous, active-low on sys_rst; sampled only on the xclk rising edge.
- Reset values:
  - All outputs 0; FSM = IDLE.
  - Step table entries 0 (mode OFF, dur 0); ctl = 0; prescaler 0.
- Step entry write: {mode[1:0], dur[5:0]} = wr_data[7:6], wr_data[5:0].
- Control register write:
  - wr_data[0] = enable; wr_data[1] = loop.
  - wr_data[2+STEP_AW-1:2] = last (index of final step).
  - Unused bits ignored.
- Mode encoding:
  - 00 OFF: r=g=0.
  - 01 ALT: r=red_flash, g=green_flash.
  - 10 SYNC: r=g=red_flash.
  - 11 ON: r=g=1.
- Prescaler: counts 0..PRESCALE-1 in RUN only, cleared otherwise. Tick is asserted in the cycle the count equals PRESCALE-1, then the count wraps to 0.
- A step of dur D lasts D+1 ticks. The duration counter is loaded from the table at step entry; later table writes to the active step change its mode immediately but not its remaining duration.
- FSM:
  - IDLE: cur_step=0. If enable=1 the next state is RUN; the duration counter loads from step 0 and the prescaler clears.
  - RUN, on a tick with dcnt>0: dcnt decrements.
  - RUN, on a tick with dcnt==0 and cur_step!=last: cur_step+1, reload dcnt.
  - RUN, on a tick with dcnt==0 and cur_step==last, loop=1: cur_step=0, reload, wrap=1 for 1 cycle.
  - RUN, on a tick with dcnt==0 and cur_step==last, loop=0: go to DONE.
  - RUN, enable=0 (control write): IDLE next cycle, takes priority over the tick.
  - DONE: done=1, LEDs off; enable=0 -> IDLE. Rewriting enable=1 while in DONE does not restart; enable must be cleared first.
- Control write with enable=1 during RUN updates loop/last without restart.
- If last < cur_step, the sequence runs to N_STEPS-1, then wraps (loop) or finishes by the same rules at index N_STEPS-1 (cur_step wraps modulo N_STEPS).
- Outputs:
  - led_r/led_g are registered: the value is one xclk after the mode/flash inputs.
  - LEDs are 0 in IDLE and DONE.
  - busy and done are registered from FSM state.
- Simultaneous write and tick on the step being loaded: the newly written value is loaded (write-through).

Optional Feature:
- Macro: LEDSEQ_READBACK_EN.
- Defined: adds ports rd_addr (in, STEP_AW+1) and rd_data (out, 8).
  - rd_data is registered, 1-cycle latency.
  - Step address returns {mode, dur}.
  - Control address returns {status in bits 7:6 = {done, busy}, last, loop, enable}.
- Undefined: ports absent, no readback logic.

Test Plan:
- Reset, PRESCALE=4: hold sys_rst=0 for 2 cycles with wr_en pulsing -> all outputs 0; table and ctl unchanged at 0 after release.
- Steps 0..3 = 8'h41, 8'h80, 8'hC2, 8'h00; ctl=8'h0D (enable, last=3, no loop) -> durations 2, 1, 3, 1 ticks (8, 4, 12, 4 cycles).
  - cur_step sequence is 0,1,2,3; then done=1 and LEDs 0.
  - During step 2, led_r=led_g=1 one cycle after entry.
- Same table, ctl=8'h0F (loop) -> wrap pulses exactly once per 28 cycles; cur_step returns to 0; busy stays 1.
- Write ctl=8'h00 mid-step 1 in a tick cycle -> IDLE the next cycle; LEDs 0; cur_step=0; no step advance.
- ALT mode: toggle red_flash/green_flash independently -> led_r/led_g follow with exactly 1-cycle latency.
- DONE, then rewrite ctl=8'h0D -> stays DONE; ctl=8'h00 then 8'h0D -> restarts at step 0.
